// File: rtl/lsu_pkg.sv
// Shared state, funct3, error-code and request-holding types for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST_WR,
        LD_ADDR,
        LD_DATA,
        RESP
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] LSU_OK       = 2'b00;
    localparam logic [1:0] LSU_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_RANGE    = 2'b10;
    localparam logic [1:0] LSU_ILLEGAL  = 2'b11;

    typedef struct packed {
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } lsu_req_t;

endpackage

// File: rtl/lsu_access_check.sv
// Combinational legality check of a load/store request; returns the highest-priority fault cause.
// Priority: illegal funct3, then misalignment, then out-of-range address.
module lsu_access_check
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    output logic [1:0]  err
);

    logic        illegal;
    logic        half;
    logic        word;
    logic [31:0] addr_hi;

    always_comb begin
        illegal = is_store ? (funct3 > SW) : !(funct3 inside {LB, LH, LW, LBU, LHU});
        half    = is_store ? (funct3 == SH) : (funct3 == LH || funct3 == LHU);
        word    = (funct3 == LW);
        // Anything left after dropping the in-range byte offset bits is out of range.
        addr_hi = addr >> (ADDR_WIDTH + 2);

        err = LSU_OK;
        if (illegal) begin
            err = LSU_ILLEGAL;
        end else if ((half && addr[0]) || (word && addr[1:0] != 2'b00)) begin
            err = LSU_MISALIGN;
        end else if (addr_hi != 32'd0) begin
            err = LSU_RANGE;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: checks a request, drives the BRAM, returns one response (load 3, store 2, error 1 cycle after accept).
// req_ready is low from accept until the response handshake; the response is held until resp_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_funct3,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state;
    lsu_state_t  state_nxt;
    lsu_req_t    hold_q;
    logic [1:0]  chk_err;
    logic [1:0]  err_q;
    logic [31:0] rdata_q;
    logic        rdata_live_q;
    logic        accept;

    lsu_access_check #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_check (
        .is_store (req_is_store),
        .addr     (req_addr),
        .funct3   (req_funct3),
        .err      (chk_err)
    );

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign stall     = req_valid && !req_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (chk_err != LSU_OK) begin
                        state_nxt = RESP;
                    end else if (req_is_store) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = LD_ADDR;
                    end
                end
            end
            ST_WR:   state_nxt = RESP;
            LD_ADDR: state_nxt = LD_DATA;
            LD_DATA: state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            err_q        <= LSU_OK;
            rdata_q      <= '0;
            rdata_live_q <= 1'b0;
        end else begin
            rdata_live_q <= (state == LD_DATA);
            if (accept) begin
                hold_q <= '{is_store: req_is_store, addr: req_addr,
                            wdata: req_wdata, funct3: req_funct3};
                err_q   <= chk_err;
                rdata_q <= '0;
            end else if (rdata_live_q) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    // Memory output is only valid in the first response cycle; it is forwarded then and held from rdata_q after.
    assign resp_rdata     = rdata_live_q ? mem_read_data : rdata_q;
    assign resp_err       = err_q;
    assign resp_valid     = (state == RESP);

    assign mem_address    = hold_q.addr;
    assign mem_write_data = hold_q.wdata;
    assign mem_funct3     = hold_q.funct3;
    assign mem_write      = (state == ST_WR);
    assign mem_read       = (state == LD_ADDR) || (state == LD_DATA);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, mid-load reset, then random requests scored
// against a byte-array reference model; a two-stage BRAM model serves the memory port.
module tb_load_store_unit;

    localparam int AW        = 10;
    localparam int MEM_BYTES = 4 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        stall;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_funct3;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data = '0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_funct3     (req_funct3),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .stall          (stall),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_funct3     (mem_funct3),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    // BRAM: array read registered on the first read cycle, extended result registered on the second.
    logic [7:0]  bram [0:MEM_BYTES-1] = '{default: 8'h00};
    logic [31:0] bram_raw = '0;

    function automatic logic [31:0] bram_ext(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_funct3[1:0])
                2'b00: bram[mem_address[AW+1:0]] <= mem_write_data[7:0];
                2'b01: begin
                    bram[{mem_address[AW+1:1], 1'b0}] <= mem_write_data[7:0];
                    bram[{mem_address[AW+1:1], 1'b1}] <= mem_write_data[15:8];
                end
                default: begin
                    bram[{mem_address[AW+1:2], 2'd0}] <= mem_write_data[7:0];
                    bram[{mem_address[AW+1:2], 2'd1}] <= mem_write_data[15:8];
                    bram[{mem_address[AW+1:2], 2'd2}] <= mem_write_data[23:16];
                    bram[{mem_address[AW+1:2], 2'd3}] <= mem_write_data[31:24];
                end
            endcase
        end
        if (mem_read) begin
            bram_raw <= {bram[{mem_address[AW+1:2], 2'd3}], bram[{mem_address[AW+1:2], 2'd2}],
                         bram[{mem_address[AW+1:2], 2'd1}], bram[{mem_address[AW+1:2], 2'd0}]};
            mem_read_data <= bram_ext(bram_raw, mem_address[1:0], mem_funct3);
        end
    end

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          hold;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [0:MEM_BYTES-1] = '{default: 8'h00};

    // Reference: legality rules, little-endian byte memory, sign/zero extension.
    task automatic ref_model(inout vec_t v);
        int size;
        size = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        if (v.st ? (v.f3 > 3'd2) : (v.f3 == 3'd3 || v.f3 >= 3'd6)) v.exp_err = 2'd3;
        else if (v.addr % size != 0)                                v.exp_err = 2'd1;
        else if (v.addr >= MEM_BYTES)                               v.exp_err = 2'd2;
        else                                                        v.exp_err = 2'd0;
        v.exp_rdata = '0;
        if (v.exp_err == 2'd0) begin
            for (int i = 0; i < size; i++) begin
                if (v.st) ref_mem[int'(v.addr) + i] = v.wdata[8*i +: 8];
                else      v.exp_rdata[8*i +: 8] = ref_mem[int'(v.addr) + i];
            end
            if (!v.st && !v.f3[2] && size < 4 && v.exp_rdata[8*size-1])
                v.exp_rdata = v.exp_rdata | (32'hFFFF_FFFF << (8*size));
        end
    endtask

    task automatic chk(input int idx, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %h, want %h", idx, what, act, exp);
        end
    endtask

    task automatic drive_junk();
        req_valid    = 1'($urandom);
        req_is_store = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_funct3   = 3'($urandom);
    endtask

    // Starts at a negedge with the unit idle; ends at a negedge with the unit idle again.
    task automatic run_vec(input int idx, input vec_t v);
        int   lat, nwr, nrd, exp_lat;
        logic got, busy_ok, both_ok, stable;
        logic [31:0] rd;
        logic [1:0]  er;
        req_valid    = 1'b1;
        req_is_store = v.st;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_funct3   = v.f3;
        resp_ready   = (v.hold == 0);
        chk(idx, "req_ready idle", 32'(req_ready), 32'd1);
        lat = 0; nwr = 0; nrd = 0; got = 1'b0; busy_ok = 1'b1; both_ok = 1'b1;
        @(posedge clk);
        #1 drive_junk();
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            nwr += int'(mem_write);
            nrd += int'(mem_read);
            if (mem_write && mem_read) both_ok = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
            end else begin
                if (stall !== req_valid || req_ready !== 1'b0) busy_ok = 1'b0;
                drive_junk();
            end
        end
        exp_lat = (v.exp_err != 2'd0) ? 1 : (v.st ? 2 : 3);
        chk(idx, "resp latency", lat, exp_lat);
        chk(idx, "resp_err", 32'(resp_err), 32'(v.exp_err));
        chk(idx, "resp_rdata", resp_rdata, v.exp_rdata);
        chk(idx, "mem_write cycles", nwr, (v.exp_err == 2'd0 && v.st) ? 1 : 0);
        chk(idx, "mem_read cycles", nrd, (v.exp_err == 2'd0 && !v.st) ? 2 : 0);
        chk(idx, "busy stall/ready", {busy_ok, both_ok}, 2'b11);
        rd = resp_rdata;
        er = resp_err;
        req_valid = (v.hold > 0);
        if (v.hold > 0) begin
            stable = 1'b1;
            for (int k = 1; k < v.hold; k++) begin
                @(negedge clk);
                if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready || !stall)
                    stable = 1'b0;
            end
            chk(idx, "held response", 32'(stable), 32'd1);
            resp_ready = 1'b1;
            req_valid  = 1'b0;
        end
        @(negedge clk);
        chk(idx, "back idle {ready,valid}", {req_ready, resp_valid}, 2'b10);
    endtask

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, input int hold, input logic [1:0] e,
                                input logic [31:0] rd);
        vec_t v;
        v = '{st: st, addr: a, wdata: wd, f3: f3, hold: hold, exp_err: e, exp_rdata: rd};
        return v;
    endfunction

    initial begin
        vec_t v;
        vec_t m;
        int   idx;

        tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 2'd0, 32'h0));
        tbl.push_back(mk(0, 32'h10, 32'h0,        3'b010, 5, 2'd0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 32'h13, 32'h12345680, 3'b000, 0, 2'd0, 32'h0));
        tbl.push_back(mk(0, 32'h13, 32'h0,        3'b000, 0, 2'd0, 32'hFFFFFF80));
        tbl.push_back(mk(0, 32'h13, 32'h0,        3'b100, 0, 2'd0, 32'h00000080));
        tbl.push_back(mk(0, 32'h10, 32'h0,        3'b010, 0, 2'd0, 32'h80ADBEEF));
        tbl.push_back(mk(0, 32'h11, 32'h0,        3'b001, 0, 2'd1, 32'h0));
        tbl.push_back(mk(0, 32'h1000, 32'h0,      3'b010, 0, 2'd2, 32'h0));
        tbl.push_back(mk(0, 32'h11, 32'h0,        3'b011, 0, 2'd3, 32'h0));
        tbl.push_back(mk(1, 32'h12, 32'hAAAA7FFF, 3'b001, 0, 2'd0, 32'h0));
        tbl.push_back(mk(0, 32'h12, 32'h0,        3'b001, 0, 2'd0, 32'h00007FFF));
        tbl.push_back(mk(0, 32'h10, 32'h0,        3'b010, 0, 2'd0, 32'h7FFFBEEF));
        tbl.push_back(mk(1, 32'h10, 32'h55555555, 3'b011, 0, 2'd3, 32'h0));
        tbl.push_back(mk(1, 32'hFFC, 32'h01020304, 3'b010, 0, 2'd0, 32'h0));
        tbl.push_back(mk(0, 32'hFFE, 32'h0,       3'b001, 0, 2'd0, 32'h00000102));
        tbl.push_back(mk(0, 32'hFFF, 32'h0,       3'b000, 0, 2'd0, 32'h00000001));
        tbl.push_back(mk(1, 32'h1000, 32'h11,     3'b000, 0, 2'd2, 32'h0));
        tbl.push_back(mk(1, 32'h2, 32'h22,        3'b010, 0, 2'd1, 32'h0));
        tbl.push_back(mk(0, 32'h80000010, 32'h0,  3'b010, 0, 2'd2, 32'h0));
        tbl.push_back(mk(0, 32'h12, 32'h0,        3'b101, 2, 2'd0, 32'h00007FFF));
        tbl.push_back(mk(0, 32'h20, 32'h0,        3'b110, 0, 2'd3, 32'h0));
        tbl.push_back(mk(0, 32'h20, 32'h0,        3'b111, 0, 2'd3, 32'h0));
        tbl.push_back(mk(0, 32'h1001, 32'h0,      3'b001, 0, 2'd1, 32'h0));
        tbl.push_back(mk(0, 32'hFFE, 32'h0,       3'b010, 0, 2'd1, 32'h0));

        repeat (3) @(negedge clk);
        chk(0, "reset {req_ready,resp_valid,stall}", {req_ready, resp_valid, stall}, 3'b100);
        chk(0, "reset resp_rdata/err", {resp_rdata, resp_err}, 34'h0);
        chk(0, "reset mem_address", mem_address, 32'h0);
        chk(0, "reset mem_write_data", mem_write_data, 32'h0);
        chk(0, "reset mem_funct3/write/read", {mem_funct3, mem_write, mem_read}, 5'h0);
        rst_n = 1'b1;
        @(negedge clk);

        idx = 1;
        foreach (tbl[i]) begin
            m = tbl[i];
            ref_model(m);
            run_vec(idx, tbl[i]);
            idx++;
        end

        // Reset while the load sits in LD_DATA; strobes must drop without waiting for a clock edge.
        resp_ready = 1'b1;
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(idx, "mem_read in LD_DATA", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk(idx, "mid-reset strobes", {mem_read, mem_write, resp_valid, stall}, 4'b0000);
        chk(idx, "mid-reset req_ready", 32'(req_ready), 32'd1);
        chk(idx, "mid-reset mem_address", mem_address, 32'h0);
        chk(idx, "mid-reset resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(idx, "post-reset no stale resp", 32'(resp_valid), 32'd0);
        idx++;
        v = mk(0, 32'h10, 32'h0, 3'b010, 0, 2'd0, 32'h0);
        ref_model(v);
        run_vec(idx, v);
        idx++;

        for (int r = 0; r < 150; r++) begin
            v.st    = 1'($urandom);
            v.wdata = $urandom;
            v.f3    = 3'($urandom);
            v.hold  = $urandom_range(0, 2);
            case ($urandom_range(0, 7))
                0:       v.addr = $urandom;
                1:       v.addr = $urandom_range(32'hFF8, 32'h1007);
                default: v.addr = $urandom_range(0, 31);
            endcase
            ref_model(v);
            run_vec(idx, v);
            idx++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage sequencer between the execute stage and the byte-addressable data memory (BRAM, 1-cycle array read plus registered, extended `read_data`, so 2 cycles of load latency). It accepts one load/store request at a time over a valid/ready handshake and checks it for illegal `funct3`, misalignment and out-of-range address. It holds address, `funct3` and strobes stable for exactly as long as the memory needs them, then returns a single response with load data or an error cause. It also provides the pipeline stall signal.

## Interface
- `ADDR_WIDTH`, 10: word-address bits of data memory; legal byte range is 0 .. 4·2^ADDR_WIDTH − 1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (low byte/half used for SB/SH).
- `req_funct3` in 3: RV32I load/store `funct3`.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 out of range, 11 illegal `funct3`.
- `stall` out 1: asserted when `req_valid` is high and `req_ready` is low.
- `mem_address` out 32, `mem_write_data` out 32, `mem_funct3` out 3, `mem_write` out 1, `mem_read` out 1: drive the data memory.
- `mem_read_data` in 32: registered, extended load result from memory.

## Operation
- States: IDLE, ST_WR, LD_ADDR, LD_DATA, RESP.
- IDLE:
  - `req_ready`=1.
  - Accept on `req_valid` && `req_ready`: capture `is_store`, addr, wdata, `funct3` into holding registers.
  - Run the checks on the request inputs (priority high to low):
    - Illegal: load `funct3` ∈ {011,110,111}; store `funct3` > 010.
    - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
    - Out of range: addr[31:ADDR_WIDTH+2] ≠ 0.
  - Any check fails: next state RESP with the cause; no memory access.
  - Otherwise next state ST_WR (store) or LD_ADDR (load).
- ST_WR: `mem_write`=1 for exactly one cycle, then RESP with `resp_err`=00 and `resp_rdata`=0.
- LD_ADDR: `mem_read`=1; the array samples the address. Next state LD_DATA.
- LD_DATA: `mem_read`=1 with address and `funct3` held; memory registers the extended data. Next state RESP and capture `mem_read_data` into the response register on the following edge.
- RESP:
  - `resp_valid`=1; hold `resp_rdata`/`resp_err` until `resp_ready`.
  - On handshake go to IDLE. No request is accepted in the same cycle as the handshake.
- `mem_address`, `mem_write_data` and `mem_funct3` always come from the holding registers, never straight from `req_*`.
- `mem_read` and `mem_write` are decoded from the state and are never both 1.

## Timing
- Reset values: state IDLE, `req_ready`=1, and every other output 0 (`resp_valid`, `resp_rdata`, `resp_err`, `stall`, `mem_*`). Holding registers are cleared to 0.
- Accept at edge T. Relative to that edge:
  - Load: LD_ADDR in cycle T+1, LD_DATA in T+2, `resp_valid` in T+3.
  - Store: `mem_write` in T+1, `resp_valid` in T+2.
  - Error: `resp_valid` in T+1.
- Minimum load throughput is 1 per 4 cycles; stores 1 per 3 cycles.
- `resp_ready` may be held high in advance; the response still lasts at least one cycle.
- Reset asserted mid-operation: all strobes drop immediately (asynchronously). Any in-flight store is either complete or not started; a pending response is discarded.
- `req_*` changes while not ready are ignored.

## Structure
- `lsu_pkg`: state enum `lsu_state_t`; `funct3` constants (LB, LH, LW, LBU, LHU, SB, SH, SW); error codes `LSU_OK`, `LSU_MISALIGN`, `LSU_RANGE`, `LSU_ILLEGAL`.
- One combinational sub-module, `lsu_access_check`, takes `is_store`, addr, `funct3` and `ADDR_WIDTH` and returns the 2-bit cause. The FSM and registers live in the top.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → `mem_write` pulses once at T+1; load `resp_valid` at T+3 with `resp_rdata`=0xDEADBEEF, `resp_err`=00.
- SB 0x13 data 0x80, then LB 0x13 and LBU 0x13 → 0xFFFFFF80 and 0x00000080; the other bytes of word 0x10 are unchanged.
- LH 0x11 → `resp_err`=01 at T+1; `mem_read` and `mem_write` never asserted.
- LW 0x1000 (ADDR_WIDTH=10) → `resp_err`=10. Load with `funct3`=011 at a misaligned address → `resp_err`=11, since illegal has priority.
- Hold `resp_ready`=0 for 5 cycles on a LW response → `resp_valid` and data stable, `req_ready`=0, `stall`=1 while `req_valid` is high. Release → return to IDLE the next cycle.
- Drive `rst_n` low during LD_DATA → outputs 0 immediately, state IDLE. The first request after reset completes normally.
